// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scoreboard.
// Combinational helpers only; no state, no flow control.
package regfile_pkg;

    localparam int RF_DEF_DATA_W   = 32;
    localparam int RF_DEF_NUM_REGS = 15;
    localparam int RF_DEF_NUM_RD   = 2;
    localparam int RF_DEF_AW       = 4;

    // Write-back ports are resolved low-then-high; the high port wins a same-address collision.
    localparam int RF_NUM_WB  = 2;
    localparam int RF_WB_ALU  = 0;
    localparam int RF_WB_LOAD = 1;
    localparam int RF_WB_LO   = RF_WB_ALU;
    localparam int RF_WB_HI   = RF_WB_LOAD;

    localparam int RF_RST_W = 64;

    function automatic logic [RF_RST_W-1:0] rf_reset_val(input int idx);
        logic [RF_RST_W-1:0] v;
        v       = '0;
        v[31:0] = idx;
        return v;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back or flush.
// Latency: updates on the rising edge, visible the next cycle.
// Backpressure: none; every request is accepted in the cycle it is presented.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_DEF_NUM_REGS,
    parameter int AW       = RF_DEF_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb0_en,
    input  logic [AW-1:0]       wb0_addr,
    input  logic                wb1_en,
    input  logic [AW-1:0]       wb1_addr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_dest,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_nxt;

    // Priority lowest to highest: hold, flush, write-back clear, issue set.
    always_comb begin
        pending_nxt = flush ? '0 : pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wb0_en && (wb0_addr == AW'(i)))
                pending_nxt[i] = 1'b0;
            if (wb1_en && (wb1_addr == AW'(i)))
                pending_nxt[i] = 1'b0;
            if (iss_en && (iss_dest == AW'(i)))
                pending_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, two write-back ports (load wins), RAW scoreboard; RF_BYPASS_EN adds write-through.
// Latency: writes land on the rising edge; reads are combinational (same-cycle with RF_BYPASS_EN).
// Backpressure: none; hazards are reported via rd_hazard and the consumer stalls itself.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DEF_DATA_W,
    parameter int NUM_REGS = RF_DEF_NUM_REGS,
    parameter int NUM_RD   = RF_DEF_NUM_RD,
    parameter int AW       = RF_DEF_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_hazard,
    input  logic                     wb0_en,
    input  logic [AW-1:0]            wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [AW-1:0]            wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_dest,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      pending
);

    logic              wb_en   [RF_NUM_WB];
    logic [AW-1:0]     wb_addr [RF_NUM_WB];
    logic [DATA_W-1:0] wb_dat  [RF_NUM_WB];

    assign wb_en[RF_WB_ALU]    = wb0_en;
    assign wb_addr[RF_WB_ALU]  = wb0_addr;
    assign wb_dat[RF_WB_ALU]   = wb0_data;
    assign wb_en[RF_WB_LOAD]   = wb1_en;
    assign wb_addr[RF_WB_LOAD] = wb1_addr;
    assign wb_dat[RF_WB_LOAD]  = wb1_data;

    logic [DATA_W-1:0]   regs   [NUM_REGS];
    logic [NUM_REGS-1:0] wr_vld;
    logic [DATA_W-1:0]   wr_dat [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_vld[i] = 1'b0;
            wr_dat[i] = '0;
            if (wb_en[RF_WB_LO] && (wb_addr[RF_WB_LO] == AW'(i))) begin
                wr_vld[i] = 1'b1;
                wr_dat[i] = wb_dat[RF_WB_LO];
            end
            if (wb_en[RF_WB_HI] && (wb_addr[RF_WB_HI] == AW'(i))) begin
                wr_vld[i] = 1'b1;
                wr_dat[i] = wb_dat[RF_WB_HI];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= DATA_W'(rf_reset_val(i));
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_vld[i])
                    regs[i] <= wr_dat[i];
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .iss_en   (iss_en),
        .iss_dest (iss_dest),
        .flush    (flush),
        .pending  (pending)
    );

    // Out-of-range addresses match no register and fall through to data 0, hazard 0.
    always_comb begin
        rd_data   = '0;
        rd_hazard = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr[p*AW +: AW] == AW'(i)) begin
                    rd_data[p*DATA_W +: DATA_W] = regs[i];
                    rd_hazard[p]                = pending[i];
                end
            end
`ifdef RF_BYPASS_EN
            if (int'(rd_addr[p*AW +: AW]) < NUM_REGS) begin
                if (wb_en[RF_WB_LO] && (wb_addr[RF_WB_LO] == rd_addr[p*AW +: AW])) begin
                    rd_data[p*DATA_W +: DATA_W] = wb_dat[RF_WB_LO];
                    rd_hazard[p]                = 1'b0;
                end
                if (wb_en[RF_WB_HI] && (wb_addr[RF_WB_HI] == rd_addr[p*AW +: AW])) begin
                    rd_data[p*DATA_W +: DATA_W] = wb_dat[RF_WB_HI];
                    rd_hazard[p]                = 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the ARM pipeline core; next generation of the single-write, two-read file.
- Generic width, depth and read-port count.
- Two write-back ports: WB0 for ALU results, WB1 for load data.
- Per-register pending-write scoreboard so ID can detect RAW hazards without a separate hazard unit.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 15, number of architectural registers (R0..R14; PC held elsewhere)
NUM_RD, 2, number of read ports
AW, 4, register address width; must satisfy 2**AW >= NUM_REGS

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  packed read addresses; port p at [p*AW +: AW]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_hazard  out  NUM_RD  port p reads a register with a write still pending
wb0_en  in  1  ALU write-back enable
wb0_addr  in  AW  ALU write-back destination
wb0_data  in  DATA_W  ALU write-back value
wb1_en  in  1  load write-back enable
wb1_addr  in  AW  load write-back destination
wb1_data  in  DATA_W  load write-back value
iss_en  in  1  instruction issued with a register destination
iss_dest  in  AW  destination of the issued instruction
flush  in  1  pipeline flush; clears the scoreboard
pending  out  NUM_REGS  current scoreboard bits

Behaviour:
- Reset (rst low, asynchronous):
  - R[i] <= i, zero-extended to DATA_W.
  - pending <= 0.
  - rd_hazard combinationally 0 while pending is 0.
  - Reset mid-operation discards all in-flight writes and issues.
- Writes happen on the rising clk edge, one-cycle latency.
  - Addresses >= NUM_REGS are ignored.
  - wb0_en && wb1_en to the same address in one cycle: WB1 (load) wins; WB0 is dropped.
  - Different addresses in the same cycle: both are written.
- Reads are combinational.
  - rd_data[p] = R[rd_addr[p]].
  - Address >= NUM_REGS returns 0 with rd_hazard[p] = 0.
- Scoreboard, evaluated at the rising edge:
  - Clear: pending[a] <= 0 for any address a written by an enabled WB port.
  - Set: pending[iss_dest] <= 1 when iss_en and iss_dest < NUM_REGS.
  - Set and clear of the same register in one cycle: set wins (the new instruction owns the register).
  - flush clears all bits except a same-cycle set, which still applies.
  - Writes never depend on pending. An unsolicited write-back is still performed, and clears an already-0 bit harmlessly.
- rd_hazard[p] = pending[rd_addr[p]]. With RF_BYPASS_EN, it is instead masked when a same-cycle write-back to that address is forwarded.
- No internal FSM beyond the scoreboard register. State consists of the NUM_REGS x DATA_W array plus the NUM_REGS pending bits.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-through forwarding):
  - If an enabled WB port targets rd_addr[p] in the current cycle, rd_data[p] returns that WB data, with WB1 taking priority over WB0.
  - rd_hazard[p] is forced to 0 for that port.
  - Adds a combinational path from wb*_data to rd_data.
- Undefined:
  - Reads return the pre-edge array value.
  - rd_hazard reflects the raw pending bit.
  - The consumer stalls one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - the reset-value function (index to DATA_W);
  - localparams for WB port priority and the default widths.
- One natural sub-module: rf_scoreboard.
  - Holds the pending vector plus set/clear/flush priority logic.
  - Instantiated once; the top module holds the array, write muxing and the read/bypass muxes.

Test Plan:
- Reset: rst low with clk running, then release -> rd_addr = 5 reads 5, rd_addr = 14 reads 14; pending = 0; rd_hazard = 0.
- Write collision: wb0 (addr 3, 0xAAAA_0000) and wb1 (addr 3, 0x5555_1111) in the same cycle -> next cycle R3 reads 0x5555_1111. Separately, wb0 to addr 2 and wb1 to addr 7 in the same cycle -> both updated.
- Scoreboard:
  - iss_en with dest 4 -> pending[4] = 1 and rd_hazard = 1 on a port reading R4.
  - wb0 to 4 two cycles later -> pending[4] = 0.
  - Same-cycle iss_en dest 4 and wb0 to 4 -> pending[4] remains 1.
- Bypass:
  - With RF_BYPASS_EN: pending[6] = 1, wb1 to 6 with 0xDEAD_BEEF, rd_addr0 = 6 in the same cycle -> rd_data0 = 0xDEAD_BEEF and rd_hazard[0] = 0.
  - Without the macro: rd_data0 returns the old value and rd_hazard[0] = 1.
- Flush/out-of-range:
  - Set pending on 1, 2, 9, then flush together with iss_en dest 9 -> pending = only bit 9.
  - Read addr 15 with NUM_REGS = 15 -> data 0, hazard 0.
  - wb0 to addr 15 -> no register changes.
- Async reset mid-operation:
  - Pending bits set and R3 written, then rst pulsed low between clk edges -> outputs return to reset values immediately, without waiting for a clock edge.
  - The concurrent write is lost.
